// File: rtl/interrupt_controller.sv
// Edge-latched, maskable, priority-resolving interrupt controller with a nesting stack.
// On accept it drives a fixed-length injected sequence into decode, ending in a vector redirect.
module interrupt_controller #(
    parameter int NUM_IRQ = 4,
    parameter int PC_WIDTH = 32,
    parameter int INJ_STEPS = 3,
    parameter int NEST_DEPTH = 2,
    parameter logic [PC_WIDTH-1:0] VEC_BASE = PC_WIDTH'(32'h0000_0010),
    parameter int VEC_STRIDE = 2,
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int STEP_W = (INJ_STEPS > 1) ? $clog2(INJ_STEPS) : 1,
    localparam int LVL_W = $clog2(NEST_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    input  logic                can_accept,
    input  logic                rti_done,
    output logic                inj_valid,
    output logic [STEP_W-1:0]   inj_step,
    output logic                save_flags,
    output logic                vec_valid,
    output logic [PC_WIDTH-1:0] vec_pc,
    output logic [ID_W-1:0]     active_id,
    output logic                in_service,
    output logic [LVL_W-1:0]    nest_level,
    output logic [NUM_IRQ-1:0]  pending,
    output logic                spurious_rti
);

    typedef enum logic {IDLE, INJECT} state_t;

    state_t              state;
    logic [STEP_W-1:0]   stepCnt;
    logic [NUM_IRQ-1:0]  irqQ;
    logic [NUM_IRQ-1:0]  pendingQ;
    logic [NUM_IRQ-1:0]  maskQ;
    logic [ID_W-1:0]     stack [NEST_DEPTH];
    logic [LVL_W-1:0]    level;
    logic [PC_WIDTH-1:0] vecPcQ;
    logic                spuriousQ;

    logic [NUM_IRQ-1:0]  edges;
    logic [NUM_IRQ-1:0]  eligible;
    logic [NUM_IRQ-1:0]  winnerHot;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     topId;
    logic                accept;
    logic                pop;
    logic                lastStep;

    function automatic logic [PC_WIDTH-1:0] vectorFor(input logic [ID_W-1:0] id);
        return VEC_BASE + PC_WIDTH'(id) * PC_WIDTH'(VEC_STRIDE);
    endfunction

    assign edges    = irq_in & ~irqQ;
    assign eligible = pendingQ & ~maskQ;
    assign lastStep = (stepCnt == STEP_W'(INJ_STEPS - 1));

    // Scan downwards so the lowest eligible index (highest priority) wins.
    always_comb begin
        winner    = '0;
        winnerHot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner       = ID_W'(i);
                winnerHot    = '0;
                winnerHot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        topId = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (level == LVL_W'(i + 1)) topId = stack[i];
        end
    end

    assign accept = (state == IDLE) && can_accept && (eligible != '0) && !rti_done
                  && (level < LVL_W'(NEST_DEPTH))
                  && ((level == '0) || (winner < topId));
    assign pop    = rti_done && (level != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            stepCnt   <= '0;
            irqQ      <= '0;
            pendingQ  <= '0;
            maskQ     <= '0;
            level     <= '0;
            vecPcQ    <= '0;
            spuriousQ <= 1'b0;
        end else begin
            irqQ      <= irq_in;
            // A fresh edge on the channel being accepted re-arms it.
            pendingQ  <= (pendingQ & ~(winnerHot & {NUM_IRQ{accept}})) | edges;
            spuriousQ <= rti_done && (level == '0);
            if (mask_we) maskQ <= mask_wdata;

            if (accept) level <= level + LVL_W'(1);
            else if (pop) level <= level - LVL_W'(1);

            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= INJECT;
                        stepCnt <= '0;
                        vecPcQ  <= vectorFor(winner);
                    end
                end
                INJECT: begin
                    if (lastStep) begin
                        state   <= IDLE;
                        stepCnt <= '0;
                    end else begin
                        stepCnt <= stepCnt + STEP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stack entries are only meaningful below level, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (level == LVL_W'(i)) stack[i] <= winner;
            end
        end
    end

    assign inj_valid    = (state == INJECT);
    assign inj_step     = stepCnt;
    assign save_flags   = inj_valid && (stepCnt == '0);
    assign vec_valid    = inj_valid && lastStep;
    assign vec_pc       = vecPcQ;
    assign active_id    = topId;
    assign in_service   = (level != '0);
    assign nest_level   = level;
    assign pending      = pendingQ;
    assign spurious_rti = spuriousQ;

endmodule
